// File: rtl/scene_renderer.sv
// Temple Run playfield pixel stage: two-deep pipeline behind the VGA timing generator.
// TRACK_SCROLL_EN enables per-frame dash scrolling; without it scroll stays 0.
module scene_renderer #(
  parameter int TRACK_X0  = 128,
  parameter int LANE_W    = 128,
  parameter int PLAYER_Y0 = 400,
  parameter int PLAYER_SZ = 32,
  parameter int SPEED     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic [11:0] hdata,
  input  logic [11:0] vdata,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        lane_left,
  input  logic        lane_right,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic [1:0]  lane,
  output logic [7:0]  scroll
);
  typedef enum logic [1:0] {P_NONE, P_LEFT, P_RIGHT} pend_t;
  typedef struct packed {
    logic player;
    logic divider;
    logic track;
  } region_t;

  // 13-bit geometry so x+radius never wraps
  localparam logic [12:0] B0   = 13'(TRACK_X0);
  localparam logic [12:0] B1   = 13'(TRACK_X0 + LANE_W);
  localparam logic [12:0] B2   = 13'(TRACK_X0 + 2*LANE_W);
  localparam logic [12:0] B3   = 13'(TRACK_X0 + 3*LANE_W);
  localparam logic [12:0] C0   = 13'(TRACK_X0 + LANE_W/2);
  localparam logic [12:0] C1   = 13'(TRACK_X0 + LANE_W + LANE_W/2);
  localparam logic [12:0] C2   = 13'(TRACK_X0 + 2*LANE_W + LANE_W/2);
  localparam logic [12:0] HALF = 13'(PLAYER_SZ/2);
  localparam logic [12:0] DIV  = 13'd2;
  localparam logic [11:0] Y0   = 12'(PLAYER_Y0);
  localparam logic [11:0] Y1   = 12'(PLAYER_Y0 + PLAYER_SZ);

  function automatic logic near(input logic [12:0] x, input logic [12:0] b,
                                input logic [12:0] r);
    return (x + r > b) && (x < b + r);
  endfunction

  pend_t       pending;
  logic        boundary;
  logic [12:0] x13, cen;
  logic [7:0]  dash_row;
  region_t     region_d, region_q;
  logic [1:0]  vld_pipe, hs_pipe, vs_pipe;
  logic [11:0] rgb;

  assign boundary = pix_en && (hdata == 12'd0) && (vdata == 12'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= P_NONE;
      lane    <= 2'd1;
      scroll  <= 8'd0;
    end else begin
      if (boundary) begin
        case (pending)
          P_LEFT:  if (lane != 2'd0) lane <= lane - 2'd1;
          P_RIGHT: if (lane != 2'd2) lane <= lane + 2'd1;
          default: ;
        endcase
`ifdef TRACK_SCROLL_EN
        scroll <= scroll + 8'(SPEED);
`else
        scroll <= 8'd0;
`endif
      end
      // a request on the boundary edge itself survives to the next frame
      if (lane_left && !lane_right)      pending <= P_LEFT;
      else if (lane_right && !lane_left) pending <= P_RIGHT;
      else if (boundary)                 pending <= P_NONE;
    end
  end

  always_comb begin
    x13      = {1'b0, hdata};
    dash_row = vdata[7:0] + scroll;
    case (lane)
      2'd0:    cen = C0;
      2'd2:    cen = C2;
      default: cen = C1;
    endcase
    region_d.track   = (x13 >= B0) && (x13 < B3);
    region_d.divider = near(x13, B0, DIV) || near(x13, B3, DIV) ||
                       ((near(x13, B1, DIV) || near(x13, B2, DIV)) && !dash_row[5]);
    region_d.player  = (vdata >= Y0) && (vdata < Y1) && near(x13, cen, HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= 2'b00;
      hs_pipe  <= 2'b11;
      vs_pipe  <= 2'b11;
      region_q <= '0;
      rgb      <= 12'h000;
    end else if (pix_en) begin
      vld_pipe <= {vld_pipe[0], valid};
      hs_pipe  <= {hs_pipe[0], hsync_in};
      vs_pipe  <= {vs_pipe[0], vsync_in};
      region_q <= region_d;
      if (!vld_pipe[0])           rgb <= 12'h000;
      else if (region_q.player)   rgb <= 12'hF80;
      else if (region_q.divider)  rgb <= 12'hFFF;
      else if (region_q.track)    rgb <= 12'h642;
      else                        rgb <= 12'h0A0;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb;
  assign hsync = hs_pipe[1];
  assign vsync = vs_pipe[1];
endmodule
